// File: rtl/spart_bus_ctrl.sv
// SPART bus-side controller: CPU I/O decode, baud divisor with 16x enable tick,
// transmit-load and receive-acknowledge sequencing toward the rx/tx engines.
module spart_bus_ctrl #(
    parameter logic [15:0] DIV_RESET = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    input  logic [7:0] rx_data,
    input  logic       rda_in,
    input  logic       tx_busy,
    output logic       enable,
    output logic [7:0] tx_data,
    output logic       tx_load,
    output logic       rx_ack,
    output logic       tbr
);

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } baud_state_t;

    localparam baud_state_t STATE_RESET = (DIV_RESET != 16'd0) ? ST_RUN : ST_STOP;

    baud_state_t state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  shadow_lo_q, shadow_lo_d;
    logic        enable_q, enable_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_load_q, tx_load_d;
    logic        tx_pending_q, tx_pending_d;
    logic        rx_ack_q, rx_ack_d;
    logic        ovr_q, ovr_d;

    logic        bus_rd;
    logic        bus_wr;
    logic        wr_data;
    logic        wr_div_lo;
    logic        wr_div_hi;
    logic        rd_data;
    logic        rd_status;
    logic        tbr_int;
    logic [15:0] new_div;

    assign bus_rd    = iocs & iorw;
    assign bus_wr    = iocs & ~iorw;
    assign wr_data   = bus_wr && (ioaddr == ADDR_DATA);
    assign wr_div_lo = bus_wr && (ioaddr == ADDR_DIV_LO);
    assign wr_div_hi = bus_wr && (ioaddr == ADDR_DIV_HI);
    assign rd_data   = bus_rd && (ioaddr == ADDR_DATA);
    assign rd_status = bus_rd && (ioaddr == ADDR_STATUS);
    assign new_div   = {db_in, shadow_lo_q};

    // Buffer readiness depends only on the pending flop and the engine's busy flag,
    // never on the bus decode, so it has no combinational path from the CPU side.
    assign tbr_int = ~tx_pending_q & ~tx_busy;

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        cnt_d        = cnt_q;
        shadow_lo_d  = shadow_lo_q;
        enable_d     = 1'b0;
        tx_data_d    = tx_data_q;
        tx_load_d    = 1'b0;
        tx_pending_d = tx_pending_q;
        rx_ack_d     = rd_data;
        ovr_d        = ovr_q;

        if (wr_div_lo) begin
            shadow_lo_d = db_in;
        end

        // A divisor commit restarts the count and suppresses any tick due this cycle.
        if (wr_div_hi) begin
            div_d   = new_div;
            cnt_d   = new_div;
            state_d = (new_div != 16'd0) ? ST_RUN : ST_STOP;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cnt_q == 16'd0) begin
                        enable_d = 1'b1;
                        cnt_d    = div_q;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end

        if (tx_busy) begin
            tx_pending_d = 1'b0;
        end

        if (rd_status) begin
            ovr_d = 1'b0;
        end

        if (wr_data) begin
            if (tbr_int) begin
                tx_data_d    = db_in;
                tx_load_d    = 1'b1;
                tx_pending_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= STATE_RESET;
            div_q        <= DIV_RESET;
            cnt_q        <= DIV_RESET;
            shadow_lo_q  <= 8'd0;
            enable_q     <= 1'b0;
            tx_data_q    <= 8'd0;
            tx_load_q    <= 1'b0;
            tx_pending_q <= 1'b0;
            rx_ack_q     <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            shadow_lo_q  <= shadow_lo_d;
            enable_q     <= enable_d;
            tx_data_q    <= tx_data_d;
            tx_load_q    <= tx_load_d;
            tx_pending_q <= tx_pending_d;
            rx_ack_q     <= rx_ack_d;
            ovr_q        <= ovr_d;
        end
    end

    always_comb begin
        db_out = 8'd0;
        case (ioaddr)
            ADDR_DATA:   db_out = rx_data;
            ADDR_STATUS: db_out = {5'b00000, ovr_q, tbr_int, rda_in};
            ADDR_DIV_LO: db_out = div_q[7:0];
            ADDR_DIV_HI: db_out = div_q[15:8];
            default:     db_out = 8'd0;
        endcase
    end

    assign enable  = enable_q;
    assign tx_data = tx_data_q;
    assign tx_load = tx_load_q;
    assign rx_ack  = rx_ack_q;
    assign tbr     = tbr_int;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Scoreboard bench for spart_bus_ctrl: directed bus traffic pushes expectations,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_spart_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'd0;
    logic [7:0] db_in = 8'd0;
    logic [7:0] rx_data = 8'd0;
    logic       rda_in = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] db_out;
    logic       enable;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       rx_ack;
    logic       tbr;

    spart_bus_ctrl #(.DIV_RESET(16'd325)) dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .db_in   (db_in),
        .db_out  (db_out),
        .rx_data (rx_data),
        .rda_in  (rda_in),
        .tx_busy (tx_busy),
        .enable  (enable),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .rx_ack  (rx_ack),
        .tbr     (tbr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
    } exp_t;

    localparam int K_EN = 0, K_LOAD = 1, K_ACK = 2, K_TXD = 3, K_TBR = 4;

    int         tick_q[$];
    exp_t       load_q[$];
    int         ack_q[$];
    logic [7:0] rd_q[$];
    exp_t       lvl_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit tick_chk = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_lvl(input int c, input int k, input logic [7:0] v);
        exp_t e;
        e.cyc = c; e.kind = k; e.val = v;
        lvl_q.push_back(e);
    endtask

    task automatic push_reset_lvl(input int c);
        push_lvl(c, K_EN, 8'd0);
        push_lvl(c, K_LOAD, 8'd0);
        push_lvl(c, K_ACK, 8'd0);
        push_lvl(c, K_TXD, 8'd0);
        push_lvl(c, K_TBR, 8'd1);
    endtask

    task automatic push_ticks(input int base, input int per, input int n);
        for (int i = 1; i <= n; i++) tick_q.push_back(base + per * i);
    endtask

    // Monitor: one comparison per output event, decoupled from stimulus.
    initial begin
        exp_t e;
        int   act;
        string nm;
        forever begin
            @(negedge clk);
            if (enable && tick_chk) begin
                if (tick_q.size() == 0) check("unexpected_tick", cyc, -1);
                else check("tick_cycle", cyc, tick_q.pop_front());
            end
            if (tx_load) begin
                if (load_q.size() == 0) check("unexpected_tx_load", cyc, -1);
                else begin
                    e = load_q.pop_front();
                    check("tx_load_cycle", cyc, e.cyc);
                    check("tx_data", int'(tx_data), int'(e.val));
                end
            end
            if (rx_ack) begin
                if (ack_q.size() == 0) check("unexpected_rx_ack", cyc, -1);
                else check("rx_ack_cycle", cyc, ack_q.pop_front());
            end
            if (iocs && iorw) begin
                if (rd_q.size() == 0) check("unexpected_read", int'(db_out), -1);
                else check("db_out", int'(db_out), int'(rd_q.pop_front()));
            end
            while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
                e = lvl_q.pop_front();
                case (e.kind)
                    K_EN:    begin act = int'(enable);  nm = "lvl_enable";  end
                    K_LOAD:  begin act = int'(tx_load); nm = "lvl_tx_load"; end
                    K_ACK:   begin act = int'(rx_ack);  nm = "lvl_rx_ack";  end
                    K_TXD:   begin act = int'(tx_data); nm = "lvl_tx_data"; end
                    default: begin act = int'(tbr);     nm = "lvl_tbr";     end
                endcase
                check(nm, act, int'(e.val));
            end
        end
    end

    // Bus ops start one time unit after a rising edge and end likewise, so they chain back to back.
    task automatic io_write(input logic [1:0] a, input logic [7:0] d, input bit exp_load);
        exp_t e;
        if (exp_load) begin
            e.cyc = cyc + 1; e.kind = K_LOAD; e.val = d;
            load_q.push_back(e);
        end
        $display("cyc %0d write addr=%0d data=%02h", cyc, a, d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; db_in = d;
        @(posedge clk); #1;
        iocs = 1'b0;
    endtask

    task automatic io_read(input logic [1:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        if (a == 2'd0) ack_q.push_back(cyc + 1);
        $display("cyc %0d read  addr=%0d expect=%02h", cyc, a, exp);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        @(posedge clk); #1;
        iocs = 1'b0;
    endtask

    task automatic io_idle();
        @(posedge clk); #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rel;
        int c;

        // Reset state, with divisor and status visible on the bus during reset.
        @(posedge clk); #1;
        push_reset_lvl(cyc);
        io_read(2'd2, 8'h45);
        io_read(2'd3, 8'h01);
        io_read(2'd1, 8'h02);

        // Reset period: ticks every 326 clk.
        rst = 1'b0;
        rel = cyc;
        tick_chk = 1'b1;
        push_ticks(rel, 326, 4);
        wait_until(rel + 980);

        // Low byte alone leaves the live divisor untouched.
        io_write(2'd2, 8'h04, 1'b0);
        io_read(2'd2, 8'h45);
        io_read(2'd3, 8'h01);
        wait_until(rel + 1310);
        io_write(2'd3, 8'h00, 1'b0);
        c = cyc;
        push_ticks(c, 5, 3);
        io_read(2'd2, 8'h04);
        io_read(2'd3, 8'h00);
        wait_until(c + 16);

        // Zero divisor stops the tick; commit lands before the next due tick.
        io_write(2'd2, 8'h00, 1'b0);
        io_write(2'd3, 8'h00, 1'b0);
        wait_until(cyc + 30);
        io_write(2'd2, 8'h01, 1'b0);
        io_write(2'd3, 8'h00, 1'b0);
        c = cyc;
        push_ticks(c, 2, 3);
        wait_until(c + 6);
        // Hi commit lands exactly on the edge where cnt reaches zero.
        io_write(2'd2, 8'h03, 1'b0);
        io_write(2'd3, 8'h00, 1'b0);
        c = cyc;
        push_ticks(c, 4, 2);
        wait_until(c + 9);
        tick_chk = 1'b0;

        // TX load, busy handshake, overrun.
        io_read(2'd1, 8'h02);
        io_write(2'd0, 8'h5A, 1'b1);
        io_read(2'd1, 8'h00);
        tx_busy = 1'b1;
        push_lvl(cyc, K_TBR, 8'd0);
        io_idle();
        io_write(2'd0, 8'hA5, 1'b0);
        push_lvl(cyc, K_TBR, 8'd0);
        io_idle();
        tx_busy = 1'b0;
        push_lvl(cyc, K_TBR, 8'd1);
        io_idle();

        // RX read with back-to-back acks, status with overrun then cleared.
        rda_in = 1'b1;
        rx_data = 8'hC3;
        io_read(2'd0, 8'hC3);
        io_read(2'd0, 8'hC3);
        io_read(2'd1, 8'h07);
        io_read(2'd1, 8'h03);
        io_read(2'd2, 8'h03);
        io_read(2'd3, 8'h00);
        io_write(2'd1, 8'hFF, 1'b0);
        io_read(2'd1, 8'h03);
        rda_in = 1'b0;

        // Reset mid-transfer with div=5.
        io_write(2'd2, 8'h05, 1'b0);
        io_write(2'd3, 8'h00, 1'b0);
        io_write(2'd0, 8'h77, 1'b1);
        @(posedge clk); #3;
        rst = 1'b1;
        push_reset_lvl(cyc);
        @(posedge clk); #1;
        push_reset_lvl(cyc);
        io_read(2'd2, 8'h45);
        io_read(2'd3, 8'h01);
        io_read(2'd1, 8'h02);
        rst = 1'b0;
        rel = cyc;
        tick_chk = 1'b1;
        push_ticks(rel, 326, 2);
        wait_until(rel + 660);
        io_idle();

        check("ticks_outstanding", tick_q.size(), 0);
        check("loads_outstanding", load_q.size(), 0);
        check("acks_outstanding", ack_q.size(), 0);
        check("reads_outstanding", rd_q.size(), 0);
        check("levels_outstanding", lvl_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
